// File: rtl/blk_pos_ctrl_if.sv
// Frame-timing, push-button and block-position signals between the game-logic stage and its neighbours.
interface blk_pos_ctrl_if;
    logic        vsync;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_centre;
    logic [10:0] blkpos_x;
    logic [9:0]  blkpos_y;
    logic        moving;

    modport master (
        output vsync, btn_up, btn_down, btn_left, btn_right, btn_centre,
        input  blkpos_x, blkpos_y, moving
    );

    modport slave (
        input  vsync, btn_up, btn_down, btn_left, btn_right, btn_centre,
        output blkpos_x, blkpos_y, moving
    );
endinterface

// File: rtl/blk_pos_ctrl.sv
// Moves a 33x33 block from push buttons once per frame at the vsync falling edge,
// with a held-direction speed ramp and clamping inside the screen border.
module blk_pos_ctrl #(
    parameter int X_MIN        = 10,
    parameter int X_MAX        = 1237,
    parameter int Y_MIN        = 10,
    parameter int Y_MAX        = 757,
    parameter int X_INIT       = 624,
    parameter int Y_INIT       = 384,
    parameter int STEP_MAX     = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    blk_pos_ctrl_if.slave bus
);

    localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic signed [11:0] X_MIN_S = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] Y_MIN_S = 12'(Y_MIN);
    localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);

    typedef enum logic {IDLE, MOVE} state_t;

    // Bit order: {up, down, left, right, centre}
    logic [4:0]       btn_s1_q, btn_s2_q;
    logic             vs_s1_q, vs_s2_q, vs_prev_q;
    logic             tick;
    logic signed [1:0] dx, dy;
    logic             active;

    logic [10:0]      x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [3:0]       speed_q, speed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             moving_q, moving_d;

    // Add the signed step to a position and saturate into [lo, hi]; no wrap is possible.
    function automatic logic signed [11:0] sat_step(
        input logic signed [11:0] pos,
        input logic signed [1:0]  dir,
        input logic [3:0]         spd,
        input logic signed [11:0] lo,
        input logic signed [11:0] hi
    );
        logic signed [11:0] delta;
        logic signed [11:0] sum;
        delta = $signed({8'd0, spd});
        if (dir < 0)       delta = -delta;
        else if (dir == 0) delta = '0;
        sum = pos + delta;
        if (sum < lo) return lo;
        if (sum > hi) return hi;
        return sum;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            btn_s1_q  <= {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_centre};
            btn_s2_q  <= btn_s1_q;
            vs_s1_q   <= bus.vsync;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
        end
    end

    assign tick   = !vs_s2_q && vs_prev_q;
    assign dx     = $signed({1'b0, btn_s2_q[1]}) - $signed({1'b0, btn_s2_q[2]});
    assign dy     = $signed({1'b0, btn_s2_q[3]}) - $signed({1'b0, btn_s2_q[4]});
    assign active = (dx != 0) || (dy != 0);

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        speed_d  = speed_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        if (tick) begin
            if (btn_s2_q[0]) begin
                x_d     = 11'(X_INIT);
                y_d     = 10'(Y_INIT);
                speed_d = 4'd1;
                cnt_d   = '0;
                state_d = IDLE;
            end else if (active) begin
                // The move uses the speed held before this tick's ramp update.
                x_d = 11'(sat_step($signed({1'b0, x_q}), dx, speed_q, X_MIN_S, X_MAX_S));
                y_d = 10'(sat_step($signed({2'b00, y_q}), dy, speed_q, Y_MIN_S, Y_MAX_S));
                if (cnt_q == CNT_W'(ACCEL_FRAMES - 1)) begin
                    cnt_d   = '0;
                    speed_d = (speed_q < 4'(STEP_MAX)) ? speed_q + 4'd1 : 4'(STEP_MAX);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = MOVE;
            end else begin
                speed_d = 4'd1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        end
        moving_d = (state_d == MOVE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= 11'(X_INIT);
            y_q      <= 10'(Y_INIT);
            speed_q  <= 4'd1;
            cnt_q    <= '0;
            state_q  <= IDLE;
            moving_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            speed_q  <= speed_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            moving_q <= moving_d;
        end
    end

    assign bus.blkpos_x = x_q;
    assign bus.blkpos_y = y_q;
    assign bus.moving   = moving_q;

endmodule

// File: tb/tb_blk_pos_ctrl.sv
// Directed bench for blk_pos_ctrl: reset, tap, speed ramp, clamping, cancel/diagonal, centre and async reset.
module tb_blk_pos_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    blk_pos_ctrl_if bus();

    blk_pos_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_btn(input logic up, input logic down, input logic left,
                           input logic right, input logic centre);
        bus.btn_up     = up;
        bus.btn_down   = down;
        bus.btn_left   = left;
        bus.btn_right  = right;
        bus.btn_centre = centre;
    endtask

    // One short video frame: settle buttons, drop vsync, let the update land, raise vsync.
    task automatic frame();
        repeat (3) @(negedge clk);
        bus.vsync = 1'b0;
        repeat (5) @(negedge clk);
        bus.vsync = 1'b1;
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    task automatic recentre();
        set_btn(0, 0, 0, 0, 1);
        frame();
        set_btn(0, 0, 0, 0, 0);
        frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.vsync = 1'b1;
        set_btn(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.blkpos_x !== 11'd624 || bus.blkpos_y !== 10'd384 || bus.moving !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got x=%0d y=%0d mv=%0b, want x=624 y=384 mv=0",
                     bus.blkpos_x, bus.blkpos_y, bus.moving);
        end
        rst_n = 1'b1;
        frames(3);
        checks++;
        if (bus.blkpos_x !== 11'd624 || bus.blkpos_y !== 10'd384 || bus.moving !== 1'b0) begin
            failures++;
            $display("FAIL idle_frames: got x=%0d y=%0d mv=%0b, want x=624 y=384 mv=0",
                     bus.blkpos_x, bus.blkpos_y, bus.moving);
        end
    endtask

    task automatic test_tap();
        set_btn(0, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        bus.vsync = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.blkpos_x !== 11'd624) begin
            failures++;
            $display("FAIL tap_early: got x=%0d, want 624 two clocks after fall", bus.blkpos_x);
        end
        @(negedge clk);
        checks++;
        if (bus.blkpos_x !== 11'd625 || bus.moving !== 1'b1) begin
            failures++;
            $display("FAIL tap_latency: got x=%0d mv=%0b, want x=625 mv=1", bus.blkpos_x, bus.moving);
        end
        repeat (2) @(negedge clk);
        bus.vsync = 1'b1;
        set_btn(0, 0, 0, 0, 0);
        frame();
        checks++;
        if (bus.blkpos_x !== 11'd625 || bus.moving !== 1'b0) begin
            failures++;
            $display("FAIL tap_release: got x=%0d mv=%0b, want x=625 mv=0", bus.blkpos_x, bus.moving);
        end
    endtask

    task automatic test_ramp();
        int exp_x [10] = '{625, 626, 627, 628, 630, 632, 634, 636, 639, 642};
        recentre();
        set_btn(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            frame();
            checks++;
            if (bus.blkpos_x !== 11'(exp_x[i])) begin
                failures++;
                $display("FAIL ramp_frame%0d: got x=%0d, want %0d", i, bus.blkpos_x, exp_x[i]);
            end
        end
        set_btn(0, 0, 0, 0, 0);
        frame();
        set_btn(0, 0, 0, 1, 0);
        frame();
        checks++;
        if (bus.blkpos_x !== 11'd643) begin
            failures++;
            $display("FAIL ramp_restart: got x=%0d, want 643 (speed back to 1)", bus.blkpos_x);
        end
        set_btn(0, 0, 0, 0, 0);
        frame();
    endtask

    task automatic test_clamp();
        int exp_x [4] = '{11, 10, 10, 10};
        recentre();
        set_btn(0, 0, 1, 0, 0);
        frames(90);
        checks++;
        if (bus.blkpos_x !== 11'd16) begin
            failures++;
            $display("FAIL clamp_approach: got x=%0d, want 16", bus.blkpos_x);
        end
        set_btn(0, 0, 0, 0, 0);
        frame();
        set_btn(0, 0, 1, 0, 0);
        frames(4);
        set_btn(0, 0, 0, 0, 0);
        frame();
        checks++;
        if (bus.blkpos_x !== 11'd12) begin
            failures++;
            $display("FAIL clamp_setup_x: got x=%0d, want 12", bus.blkpos_x);
        end
        set_btn(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            frame();
            checks++;
            if (bus.blkpos_x !== 11'(exp_x[i])) begin
                failures++;
                $display("FAIL clamp_left%0d: got x=%0d, want %0d", i, bus.blkpos_x, exp_x[i]);
            end
        end
        set_btn(0, 1, 0, 0, 0);
        frames(62);
        checks++;
        if (bus.blkpos_y !== 10'd757 || bus.blkpos_x !== 11'd10) begin
            failures++;
            $display("FAIL clamp_bottom: got x=%0d y=%0d, want x=10 y=757", bus.blkpos_x, bus.blkpos_y);
        end
        set_btn(0, 0, 0, 0, 0);
        frame();
        set_btn(1, 0, 0, 0, 0);
        frames(8);
        set_btn(0, 0, 0, 0, 0);
        frame();
        set_btn(1, 0, 0, 0, 0);
        frames(2);
        set_btn(0, 0, 0, 0, 0);
        frame();
        checks++;
        if (bus.blkpos_y !== 10'd743) begin
            failures++;
            $display("FAIL clamp_setup_y: got y=%0d, want 743", bus.blkpos_y);
        end
        set_btn(0, 1, 0, 0, 0);
        frames(8);
        checks++;
        if (bus.blkpos_y !== 10'd755) begin
            failures++;
            $display("FAIL clamp_y755: got y=%0d, want 755", bus.blkpos_y);
        end
        frame();
        checks++;
        if (bus.blkpos_y !== 10'd757) begin
            failures++;
            $display("FAIL clamp_y_speed3: got y=%0d, want 757", bus.blkpos_y);
        end
        frame();
        checks++;
        if (bus.blkpos_y !== 10'd757 || bus.moving !== 1'b1) begin
            failures++;
            $display("FAIL clamp_y_hold: got y=%0d mv=%0b, want y=757 mv=1", bus.blkpos_y, bus.moving);
        end
        set_btn(0, 0, 0, 0, 0);
        frame();
    endtask

    task automatic test_cancel_diag();
        recentre();
        set_btn(0, 0, 1, 1, 0);
        frame();
        checks++;
        if (bus.blkpos_x !== 11'd624 || bus.blkpos_y !== 10'd384 || bus.moving !== 1'b0) begin
            failures++;
            $display("FAIL cancel_lr: got x=%0d y=%0d mv=%0b, want x=624 y=384 mv=0",
                     bus.blkpos_x, bus.blkpos_y, bus.moving);
        end
        set_btn(1, 0, 1, 0, 0);
        frame();
        checks++;
        if (bus.blkpos_x !== 11'd623 || bus.blkpos_y !== 10'd383 || bus.moving !== 1'b1) begin
            failures++;
            $display("FAIL diag_up_left: got x=%0d y=%0d mv=%0b, want x=623 y=383 mv=1",
                     bus.blkpos_x, bus.blkpos_y, bus.moving);
        end
        set_btn(0, 0, 0, 0, 0);
        frame();
    endtask

    task automatic test_centre_reset();
        recentre();
        set_btn(0, 1, 0, 1, 0);
        frames(30);
        checks++;
        if (bus.blkpos_x !== 11'd752 || bus.blkpos_y !== 10'd512 || bus.moving !== 1'b1) begin
            failures++;
            $display("FAIL diag_run: got x=%0d y=%0d mv=%0b, want x=752 y=512 mv=1",
                     bus.blkpos_x, bus.blkpos_y, bus.moving);
        end
        set_btn(0, 1, 0, 1, 1);
        frame();
        checks++;
        if (bus.blkpos_x !== 11'd624 || bus.blkpos_y !== 10'd384 || bus.moving !== 1'b0) begin
            failures++;
            $display("FAIL centre_in_move: got x=%0d y=%0d mv=%0b, want x=624 y=384 mv=0",
                     bus.blkpos_x, bus.blkpos_y, bus.moving);
        end
        set_btn(0, 0, 0, 1, 0);
        frames(6);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.blkpos_x !== 11'd624 || bus.blkpos_y !== 10'd384 || bus.moving !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got x=%0d y=%0d mv=%0b, want x=624 y=384 mv=0",
                     bus.blkpos_x, bus.blkpos_y, bus.moving);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame();
        checks++;
        if (bus.blkpos_x !== 11'd625 || bus.moving !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_move: got x=%0d mv=%0b, want x=625 mv=1", bus.blkpos_x, bus.moving);
        end
        set_btn(0, 0, 0, 0, 0);
        frame();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_tap();
        test_ramp();
        test_clamp();
        test_cancel_diag();
        test_centre_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
